// File: rtl/packet_switch_pkg.sv
// Shared constants and types for the packet_switch router.
package packet_switch_pkg;

   localparam int NUM_PORTS     = 4;
   localparam int MIN_PKT_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DROP
   } state_e;

   typedef logic [7:0] byte_t;

endpackage

// File: rtl/port_buffer.sv
// Egress packet buffer: a tentative write pointer that becomes visible only on commit,
// plus a committed pointer, a read pointer and a registered egress byte.
module port_buffer
   import packet_switch_pkg::*;
#(
   parameter int DEPTH = 512
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  wr_en,
   input  byte_t wr_data,
   input  logic  commit,
   input  logic  rewind,
   input  logic  rd_en,
   output logic  full,
   output logic  ready,
   output byte_t dout
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   byte_t       mem [DEPTH];
   logic [AW:0] wr_q;
   logic [AW:0] cm_q;
   logic [AW:0] rd_q;
   byte_t       dout_q;

   // Full is measured from the tentative pointer so an in-flight packet cannot overrun unread data.
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign ready = (rd_q != cm_q);
   assign dout  = dout_q;

   always_ff @(posedge clk) begin
      if (wr_en && !full) begin
         mem[wr_q[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q   <= '0;
         cm_q   <= '0;
         rd_q   <= '0;
         dout_q <= '0;
      end else begin
         if (rewind) begin
            wr_q <= cm_q;
         end else if (wr_en && !full) begin
            wr_q <= wr_q + PTR_ONE;
         end
         if (commit) begin
            cm_q <= wr_q;
         end
         if (rd_en && ready) begin
            dout_q <= mem[rd_q[AW-1:0]];
            rd_q   <= rd_q + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/packet_switch.sv
// Four-port packet router: DA match, ingress FSM and per-port packet buffers.
// Define PACKET_SWITCH_FCS_CHECK_EN to discard packets whose running XOR is non-zero.
module packet_switch
   import packet_switch_pkg::*;
#(
   parameter int FIFO_DEPTH = 512
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_status,
   input  logic [7:0] data,
   input  logic       mem_en,
   input  logic       mem_rd_wr,
   input  logic [1:0] mem_add,
   input  logic [7:0] mem_data,
   output logic [7:0] port0,
   output logic [7:0] port1,
   output logic [7:0] port2,
   output logic [7:0] port3,
   output logic       ready_0,
   output logic       ready_1,
   output logic       ready_2,
   output logic       ready_3,
   input  logic       read_0,
   input  logic       read_1,
   input  logic       read_2,
   input  logic       read_3
);

   byte_t                addr_q [NUM_PORTS];
   state_e               state_q;
   state_e               state_d;
   logic [1:0]           sel_q;
   logic [2:0]           cnt_q;
   logic                 hit;
   logic [1:0]           hit_idx;
   logic                 fcs_ok;
   logic [NUM_PORTS-1:0] wr_en;
   logic [NUM_PORTS-1:0] commit;
   logic [NUM_PORTS-1:0] rewind;
   logic [NUM_PORTS-1:0] full;
   logic [NUM_PORTS-1:0] ready;
   logic [NUM_PORTS-1:0] rd_en;
   byte_t                dout [NUM_PORTS];

   // Scan from the top so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = 2'd0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (data == addr_q[i]) begin
            hit     = 1'b1;
            hit_idx = 2'(i);
         end
      end
   end

`ifdef PACKET_SWITCH_FCS_CHECK_EN
   byte_t fcs_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fcs_q <= '0;
      end else if (data_status) begin
         fcs_q <= (state_q == IDLE) ? data : (fcs_q ^ data);
      end
   end

   assign fcs_ok = (fcs_q == 8'h00);
`else
   assign fcs_ok = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      wr_en   = '0;
      commit  = '0;
      rewind  = '0;
      case (state_q)
         IDLE: begin
            if (data_status) begin
               if (hit && !full[hit_idx]) begin
                  wr_en[hit_idx] = 1'b1;
                  state_d        = RECV;
               end else begin
                  state_d = DROP;
               end
            end
         end
         RECV: begin
            if (data_status) begin
               if (full[sel_q]) begin
                  rewind[sel_q] = 1'b1;
                  state_d       = DROP;
               end else begin
                  wr_en[sel_q] = 1'b1;
               end
            end else begin
               if ((cnt_q >= 3'(MIN_PKT_BYTES)) && fcs_ok) begin
                  commit[sel_q] = 1'b1;
               end else begin
                  rewind[sel_q] = 1'b1;
               end
               state_d = IDLE;
            end
         end
         DROP: begin
            if (!data_status) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         cnt_q   <= 3'd0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            addr_q[i] <= 8'h00;
         end
      end else begin
         state_q <= state_d;
         if (mem_en && mem_rd_wr) begin
            addr_q[mem_add] <= mem_data;
         end
         // Byte count only needs to reach the minimum length, so it saturates there.
         if (state_q == IDLE && data_status) begin
            sel_q <= hit_idx;
            cnt_q <= 3'd1;
         end else if (state_q == RECV && data_status && cnt_q < 3'(MIN_PKT_BYTES)) begin
            cnt_q <= cnt_q + 3'd1;
         end
      end
   end

   assign rd_en = {read_3, read_2, read_1, read_0};

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      port_buffer #(
         .DEPTH(FIFO_DEPTH)
      ) u_buf (
         .clk    (clk),
         .reset  (reset),
         .wr_en  (wr_en[gi]),
         .wr_data(data),
         .commit (commit[gi]),
         .rewind (rewind[gi]),
         .rd_en  (rd_en[gi]),
         .full   (full[gi]),
         .ready  (ready[gi]),
         .dout   (dout[gi])
      );
   end

   assign port0   = dout[0];
   assign port1   = dout[1];
   assign port2   = dout[2];
   assign port3   = dout[3];
   assign ready_0 = ready[0];
   assign ready_1 = ready[1];
   assign ready_2 = ready[2];
   assign ready_3 = ready[3];

endmodule

// File: tb/tb_packet_switch.sv
// Directed testbench for packet_switch: routing, drop, priority, FCS, overflow, streaming, reset.
module tb_packet_switch;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       data_status = 1'b0;
   logic [7:0] data = 8'h00;
   logic       mem_en = 1'b0;
   logic       mem_rd_wr = 1'b0;
   logic [1:0] mem_add = 2'd0;
   logic [7:0] mem_data = 8'h00;
   logic [7:0] po [4];
   logic [3:0] rdy;
   logic [3:0] rd = 4'b0000;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] pkt_q [$];
   logic [7:0] exp_q [$];
   logic [3:0] rdy_before;
   int         got;
   int         budget;

   always #5 clk = ~clk;

   packet_switch #(
      .FIFO_DEPTH(512)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data_status(data_status),
      .data       (data),
      .mem_en     (mem_en),
      .mem_rd_wr  (mem_rd_wr),
      .mem_add    (mem_add),
      .mem_data   (mem_data),
      .port0      (po[0]),
      .port1      (po[1]),
      .port2      (po[2]),
      .port3      (po[3]),
      .ready_0    (rdy[0]),
      .ready_1    (rdy[1]),
      .ready_2    (rdy[2]),
      .ready_3    (rdy[3]),
      .read_0     (rd[0]),
      .read_1     (rd[1]),
      .read_2     (rd[2]),
      .read_3     (rd[3])
   );

   task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_checks++;
      if (got_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
      end else begin
         $display("ok   %s: %0h", tag, got_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [1:0] a, input logic [7:0] d);
      mem_en    = 1'b1;
      mem_rd_wr = 1'b1;
      mem_add   = a;
      mem_data  = d;
      tick();
      mem_en    = 1'b0;
      mem_rd_wr = 1'b0;
   endtask

   // Builds DA, SA, LEN, payload (SA+j), XOR FCS; n is the total byte count.
   task automatic mk_pkt(input logic [7:0] da, input logic [7:0] sa, input int n);
      logic [7:0] f;
      pkt_q.delete();
      pkt_q.push_back(da);
      pkt_q.push_back(sa);
      pkt_q.push_back(8'(n - 4));
      for (int j = 0; j < n - 4; j++) pkt_q.push_back(sa + 8'(j));
      f = 8'h00;
      foreach (pkt_q[k]) f ^= pkt_q[k];
      pkt_q.push_back(f);
   endtask

   task automatic append_exp();
      foreach (pkt_q[k]) exp_q.push_back(pkt_q[k]);
   endtask

   task automatic send_pkt();
      foreach (pkt_q[k]) begin
         data_status = 1'b1;
         data        = pkt_q[k];
         tick();
      end
      rdy_before  = rdy;
      data_status = 1'b0;
      data        = 8'h00;
      tick();
   endtask

   task automatic read_byte(input int p, input logic [7:0] exp_v, input string tag);
      rd[p] = 1'b1;
      tick();
      rd[p] = 1'b0;
      check_eq(tag, {24'h0, po[p]}, {24'h0, exp_v});
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      tick();
      check_eq("reset_ready", {28'h0, rdy}, 32'h0);
      for (int p = 0; p < 4; p++) check_eq("reset_port", {24'h0, po[p]}, 32'h0);

      // Basic routing to port 1
      cfg(2'd0, 8'h10);
      cfg(2'd1, 8'h20);
      cfg(2'd2, 8'h30);
      cfg(2'd3, 8'h40);
      pkt_q = '{8'h20, 8'h77, 8'h03, 8'h01, 8'h02, 8'h03, 8'h54};
      send_pkt();
      check_eq("p1_ready_before_end", {28'h0, rdy_before}, 32'h0);
      check_eq("p1_ready_after_end", {28'h0, rdy}, 32'h2);
      foreach (pkt_q[k]) read_byte(1, pkt_q[k], "p1_byte");
      check_eq("p1_drained", {28'h0, rdy}, 32'h0);

      // Unmatched DA, then a packet to port 0
      pkt_q = '{8'h55, 8'h01, 8'h02, 8'h00, 8'h56};
      send_pkt();
      check_eq("unmatched_ready", {28'h0, rdy}, 32'h0);
      pkt_q = '{8'h10, 8'h11, 8'h01, 8'hAB, 8'hAB};
      send_pkt();
      check_eq("p0_ready", {28'h0, rdy}, 32'h1);
      foreach (pkt_q[k]) read_byte(0, pkt_q[k], "p0_byte");
      check_eq("p0_drained", {28'h0, rdy}, 32'h0);

      // Duplicate address: lowest index wins
      cfg(2'd0, 8'hAA);
      cfg(2'd2, 8'hAA);
      pkt_q = '{8'hAA, 8'h01, 8'h00, 8'hAB};
      send_pkt();
      check_eq("dup_ready", {28'h0, rdy}, 32'h1);
      foreach (pkt_q[k]) read_byte(0, pkt_q[k], "dup_byte");
      check_eq("dup_drained", {28'h0, rdy}, 32'h0);

      // Three-byte packet is below the minimum length
      pkt_q = '{8'h20, 8'h01, 8'h21};
      send_pkt();
      check_eq("short_ready", {28'h0, rdy}, 32'h0);

      // Corrupted FCS
      pkt_q = '{8'h20, 8'h77, 8'h03, 8'h01, 8'h02, 8'h03, 8'h55};
      send_pkt();
`ifdef PACKET_SWITCH_FCS_CHECK_EN
      check_eq("badfcs_ready", {28'h0, rdy}, 32'h0);
`else
      check_eq("badfcs_ready", {28'h0, rdy}, 32'h2);
      foreach (pkt_q[k]) read_byte(1, pkt_q[k], "badfcs_byte");
      check_eq("badfcs_drained", {28'h0, rdy}, 32'h0);
`endif

      // Overflow on port 3: third 200-byte packet does not fit
      exp_q.delete();
      mk_pkt(8'h40, 8'h01, 200);
      append_exp();
      send_pkt();
      check_eq("fill_a_ready", {28'h0, rdy}, 32'h8);
      mk_pkt(8'h40, 8'h02, 200);
      append_exp();
      send_pkt();
      mk_pkt(8'h40, 8'h03, 200);
      send_pkt();
      check_eq("fill_c_ready", {28'h0, rdy}, 32'h8);
      got = 0;
      while (exp_q.size() > 0) begin
         read_byte(3, exp_q.pop_front(), "fill_byte");
         got++;
      end
      check_eq("fill_count", got, 400);
      check_eq("fill_drained", {28'h0, rdy}, 32'h0);

      // Streaming: 300 bytes queued, 259 more arrive while reading
      mk_pkt(8'h40, 8'h04, 259);
      append_exp();
      send_pkt();
      mk_pkt(8'h40, 8'h05, 41);
      append_exp();
      send_pkt();
      mk_pkt(8'h40, 8'h06, 259);
      append_exp();
      got    = 0;
      budget = 0;
      fork
         send_pkt();
         begin
            while (got < 559 && budget < 3000) begin
               rd[3] = rdy[3];
               tick();
               budget++;
               if (rd[3]) begin
                  n_checks++;
                  if (po[3] !== exp_q[0]) begin
                     n_fail++;
                     $display("FAIL stream_byte %0d: got %0h expected %0h", got, po[3], exp_q[0]);
                  end
                  void'(exp_q.pop_front());
                  got++;
               end
            end
            rd[3] = 1'b0;
         end
      join
      check_eq("stream_count", got, 559);
      check_eq("stream_drained", {28'h0, rdy}, 32'h0);

      // Reset in the middle of a packet while port 0 holds data
      cfg(2'd0, 8'h10);
      pkt_q = '{8'h10, 8'h22, 8'h00, 8'h32};
      send_pkt();
      check_eq("prereset_ready", {28'h0, rdy}, 32'h1);
      data_status = 1'b1;
      data        = 8'h10;
      tick();
      data        = 8'h99;
      tick();
      reset = 1'b1;
      tick();
      check_eq("midreset_ready", {28'h0, rdy}, 32'h0);
      for (int p = 0; p < 4; p++) check_eq("midreset_port", {24'h0, po[p]}, 32'h0);
      reset       = 1'b0;
      data_status = 1'b0;
      data        = 8'h00;
      tick();
      // Cleared address registers make DA 00 route to port 0
      pkt_q = '{8'h00, 8'h05, 8'h00, 8'h05};
      send_pkt();
      check_eq("postreset_ready", {28'h0, rdy}, 32'h1);
      foreach (pkt_q[k]) read_byte(0, pkt_q[k], "postreset_byte");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
